game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter COUNTDOWN_FRAMES, default 60, frame_ticks per countdown digit.
REQ-002 SHALL have parameter DEATH_FRAMES, default 90, frame_ticks spent in DYING.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-006 SHALL have ports btn_start, btn_left, btn_right, btn_jump, btn_duck  input  1 each  debounced button levels.
REQ-007 SHALL have port game_over_in  input  1  game-over flag from the game logic.
REQ-008 SHALL have port score_in  input  16  current player score.
REQ-009 SHALL have port game_rst  output  1  reset to the game logic.
REQ-010 SHALL have port game_frame  output  1  forwarded new-frame pulse.
REQ-011 SHALL have ports cmd_left, cmd_right, cmd_jump, cmd_duck  output  1 each  per-frame player commands.
REQ-012 SHALL have port state  output  3  encoding: ATTRACT=0, COUNTDOWN=1, PLAY=2, PAUSED=3, DYING=4, OVER=5.
REQ-013 SHALL have port countdown  output  2  displayed digit (3, 2, 1), 0 outside COUNTDOWN.
REQ-014 SHALL have ports high_score  output  16  and new_record  output  1.

Function
REQ-015 Each button SHALL be rising-edge detected against its previous-cycle level; a start edge is a 0->1 transition of btn_start.
REQ-016 A left/right/jump/duck edge SHALL set a sticky flag; flags SHALL accumulate between frame_ticks.
REQ-017 In PLAY, on a frame_tick cycle: cmd_* <= flag OR same-cycle edge; all flags <= 0; game_frame <= 1 on the next cycle (latency 1).
REQ-018 cmd_* SHALL hold until the next snapshot.
REQ-019 If left and right are both captured in one snapshot, cmd_left SHALL be 1 and cmd_right 0.
REQ-020 Jump and duck SHALL be passed together unmodified.
REQ-021 game_frame SHALL be 0 in every state except PLAY, and 0 whenever game_over_in is high.
REQ-022 ATTRACT: game_rst=1; a start edge SHALL go to COUNTDOWN.
REQ-023 COUNTDOWN: game_rst=1; countdown starts at 3 and decrements every COUNTDOWN_FRAMES frame_ticks; after COUNTDOWN_FRAMES ticks at digit 1 SHALL go to PLAY with all flags cleared.
REQ-024 PLAY: game_rst=0; game_over_in=1 SHALL go to DYING on the next cycle; game_over_in SHALL take priority over a same-cycle start edge.
REQ-025 On entry to DYING: if score_in > high_score (unsigned), high_score <= score_in and new_record <= 1.
REQ-026 DYING SHALL last DEATH_FRAMES frame_ticks, then go to OVER.
REQ-027 OVER: game_rst=0, so the score stays visible; a start edge SHALL go to COUNTDOWN.
REQ-028 new_record SHALL clear on entry to COUNTDOWN.
REQ-029 game_rst, game_frame, cmd_* and state SHALL all be registered outputs.
REQ-030 The frame counter SHALL be sized $clog2 of max(COUNTDOWN_FRAMES, DEATH_FRAMES)+1 and SHALL reset to 0 on every state entry.

Reset
REQ-031 rst SHALL force state=ATTRACT, game_rst=1, game_frame=0, cmd_*=0, flags=0, countdown=0, high_score=0, new_record=0, frame counter=0.
REQ-032 rst SHALL take effect at any time, including mid-PLAY and mid-COUNTDOWN, with no forwarded frame in the reset cycle.

Configuration
REQ-033 With GAME_SEQUENCER_PAUSE_EN defined: a start edge in PLAY SHALL go to PAUSED; a start edge in PAUSED SHALL return to PLAY with flags cleared; PAUSED SHALL have game_rst=0 and game_frame=0.
REQ-034 Without GAME_SEQUENCER_PAUSE_EN: state 3 SHALL be unreachable and a start edge in PLAY SHALL be ignored.

Structure
REQ-035 Package game_pkg SHALL hold the seq_state_t enum (3-bit) and the cmd_t struct {left, right, jump, duck}.
REQ-036 Per-button edge detection and sticky flag SHALL be one sub-module, btn_edge_latch, instantiated 4 times; start uses edge detection only.

Verification (bench uses COUNTDOWN_FRAMES=2, DEATH_FRAMES=3)
REQ-037 rst, then a start edge and 6 frame_ticks -> countdown reads 3,3,2,2,1,1, then state=2 and game_rst=0.
REQ-038 In PLAY, a btn_jump pulse between ticks -> one cycle after the next tick, game_frame=1 and cmd_jump=1; after the following tick, cmd_jump=0.
REQ-039 btn_left and btn_right rise in the same cycle -> cmd_left=1, cmd_right=0.
REQ-040 score_in=0x0123 with game_over_in=1 and high_score=0 -> state=4, high_score=0x0123, new_record=1; after 3 ticks state=5; a start edge -> state=1, new_record=0, high_score stays 0x0123.
REQ-041 game_over_in=1 coincident with frame_tick -> game_frame stays 0.
REQ-042 With PAUSE_EN, a start edge in PLAY followed by 5 ticks -> no game_frame pulses; a second start edge -> state=2 and frames resume.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types for the game sequencer: top-level state encoding and the
// per-frame player command bundle.
package game_pkg;

   typedef enum logic [2:0] {
      S_ATTRACT   = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_PLAY      = 3'd2,
      S_PAUSED    = 3'd3,
      S_DYING     = 3'd4,
      S_OVER      = 3'd5
   } seq_state_t;

   typedef struct packed {
      logic left;
      logic right;
      logic jump;
      logic duck;
   } cmd_t;

   // Opposing directions in one snapshot resolve to left.
   function automatic cmd_t resolve_cmd(input cmd_t raw);
      cmd_t c;
      c = raw;
      if (raw.left && raw.right) c.right = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/btn_edge_latch.sv
// Rising-edge detector for one debounced button with a sticky flag that
// accumulates edges until cleared by the sequencer.
module btn_edge_latch (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic clr,
   output logic rise,
   output logic flag
);

   logic prev;

   assign rise = btn & ~prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev <= 1'b0;
         flag <= 1'b0;
      end else begin
         prev <= btn;
         flag <= clr ? 1'b0 : (flag | rise);
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// Game flow sequencer: attract, countdown, play, dying, game over, with
// per-frame command capture and high-score tracking.
// Optional pause state enabled by defining GAME_SEQUENCER_PAUSE_EN.
module game_sequencer
   import game_pkg::*;
#(
   parameter int COUNTDOWN_FRAMES = 60,
   parameter int DEATH_FRAMES     = 90
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        btn_start,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_jump,
   input  logic        btn_duck,
   input  logic        game_over_in,
   input  logic [15:0] score_in,
   output logic        game_rst,
   output logic        game_frame,
   output logic        cmd_left,
   output logic        cmd_right,
   output logic        cmd_jump,
   output logic        cmd_duck,
   output logic [2:0]  state,
   output logic [1:0]  countdown,
   output logic [15:0] high_score,
   output logic        new_record
);

   localparam int MAX_FRAMES = (COUNTDOWN_FRAMES > DEATH_FRAMES) ? COUNTDOWN_FRAMES : DEATH_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
   localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COUNTDOWN_FRAMES - 1);
   localparam logic [CNT_W-1:0] DY_LAST = CNT_W'(DEATH_FRAMES - 1);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       countdown_q;
   logic             start_prev, start_edge;
   logic             snap, flag_clr, cd_wrap;
   logic [3:0]       btn_v, rise_v, flag_v;
   cmd_t             cmd_q;

   assign start_edge = btn_start & ~start_prev;
   assign snap       = (state_q == S_PLAY) && frame_tick;
   // Flags only accumulate while playing; any other state discards them.
   assign flag_clr   = snap || (state_q != S_PLAY);
   assign cd_wrap    = (state_q == S_COUNTDOWN) && frame_tick && (cnt_q == CD_LAST);
   assign btn_v      = {btn_left, btn_right, btn_jump, btn_duck};

   for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_edge_latch u_latch (
         .clk  (clk),
         .rst  (rst),
         .btn  (btn_v[i]),
         .clr  (flag_clr),
         .rise (rise_v[i]),
         .flag (flag_v[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_ATTRACT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ATTRACT:   if (start_edge) state_d = S_COUNTDOWN;
         S_COUNTDOWN: if (cd_wrap && (countdown_q == 2'd1)) state_d = S_PLAY;
         S_PLAY: begin
            if (game_over_in) state_d = S_DYING;
`ifdef GAME_SEQUENCER_PAUSE_EN
            else if (start_edge) state_d = S_PAUSED;
`endif
         end
`ifdef GAME_SEQUENCER_PAUSE_EN
         S_PAUSED:    if (start_edge) state_d = S_PLAY;
`else
         S_PAUSED:    state_d = S_ATTRACT;
`endif
         S_DYING:     if (frame_tick && (cnt_q == DY_LAST)) state_d = S_OVER;
         S_OVER:      if (start_edge) state_d = S_COUNTDOWN;
         default:     state_d = S_ATTRACT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         start_prev  <= 1'b0;
         game_rst    <= 1'b1;
         game_frame  <= 1'b0;
         cmd_q       <= '0;
         cnt_q       <= '0;
         countdown_q <= 2'd0;
         high_score  <= 16'd0;
         new_record  <= 1'b0;
      end else begin
         start_prev <= btn_start;
         game_rst   <= (state_d == S_ATTRACT) || (state_d == S_COUNTDOWN);
         game_frame <= (state_q == S_PLAY) && (state_d == S_PLAY) && frame_tick;
         if (snap) cmd_q <= resolve_cmd(cmd_t'(flag_v | rise_v));

         if (state_d != state_q)
            cnt_q <= '0;
         else if (cd_wrap)
            cnt_q <= '0;
         else if (frame_tick && ((state_q == S_COUNTDOWN) || (state_q == S_DYING)))
            cnt_q <= cnt_q + 1'b1;

         if (state_d != S_COUNTDOWN)  countdown_q <= 2'd0;
         else if (state_q != S_COUNTDOWN) countdown_q <= 2'd3;
         else if (cd_wrap)            countdown_q <= countdown_q - 2'd1;

         // Score is latched on the single cycle that leaves PLAY for DYING.
         if ((state_q == S_PLAY) && (state_d == S_DYING) && (score_in > high_score)) begin
            high_score <= score_in;
            new_record <= 1'b1;
         end else if ((state_d == S_COUNTDOWN) && (state_q != S_COUNTDOWN)) begin
            new_record <= 1'b0;
         end
      end
   end

   assign state     = state_q;
   assign countdown = countdown_q;
   assign cmd_left  = cmd_q.left;
   assign cmd_right = cmd_q.right;
   assign cmd_jump  = cmd_q.jump;
   assign cmd_duck  = cmd_q.duck;

endmodule
